// File: rtl/reg_file_pkg.sv
// ============================================================================
// reg_file_pkg : shared sizing and word type for the 16x32 register file
// Revision     : 1.0
// ============================================================================
`default_nettype none

package reg_file_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  typedef logic [DATA_W-1:0] word_t;

endpackage : reg_file_pkg

`default_nettype wire

// File: rtl/reg_file_16x32.sv
// ============================================================================
// reg_file_16x32 : 16x32 register file, shared address, sync write, registered read
// Revision       : 1.0
// ============================================================================
`default_nettype none

module reg_file_16x32
  import reg_file_pkg::*;
#(
  parameter int DATA_W_P = DATA_W,
  parameter int ADDR_W_P = ADDR_W,
  parameter int DEPTH_P  = DEPTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                read_en,
  input  logic                write_en,
  input  logic [ADDR_W_P-1:0] addr,
  input  logic [DATA_W_P-1:0] write_data,
  output logic [DATA_W_P-1:0] read_data
);

  logic [DATA_W_P-1:0] mem [DEPTH_P];
  logic [DATA_W_P-1:0] rd_next;

  // Write-first bypass: a same-edge write is what the read observes.
  always_comb begin
    rd_next = mem[addr];
    if (write_en) begin
      rd_next = write_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH_P; i++) begin
        mem[i] <= '0;
      end
      read_data <= '0;
    end else begin
      if (write_en) begin
        mem[addr] <= write_data;
      end
      if (read_en) begin
        read_data <= rd_next;
      end
    end
  end

endmodule : reg_file_16x32

`default_nettype wire

// File: tb/tb_reg_file_16x32.sv
// ============================================================================
// tb_reg_file_16x32 : directed scoreboard bench for reg_file_16x32
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_reg_file_16x32;
  import reg_file_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              read_en;
  logic              write_en;
  logic [ADDR_W-1:0] addr;
  word_t             write_data;
  word_t             read_data;

  int    errors = 0;
  int    checks = 0;
  word_t model [DEPTH];
  word_t exp_q [$];
  word_t last_rd;

  reg_file_16x32 dut (
    .clk        (clk),
    .rst        (rst),
    .read_en    (read_en),
    .write_en   (write_en),
    .addr       (addr),
    .write_data (write_data),
    .read_data  (read_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input word_t exp);
    checks++;
    assert (read_data === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, read_data, exp);
    end
  endtask

  // One clock of traffic: drive on the falling edge, compare 1ns after the rising edge.
  task automatic cycle(input logic re, input logic we, input logic [ADDR_W-1:0] a,
                       input word_t d, input string tag);
    @(negedge clk);
    read_en    = re;
    write_en   = we;
    addr       = a;
    write_data = d;
    if (we) model[a] = d;
    if (re) begin
      exp_q.push_back(model[a]);
      last_rd = model[a];
    end
    @(posedge clk);
    #1;
    if (re) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL %s observed=%h expected=<empty scoreboard>", tag, read_data);
      end else begin
        check(tag, exp_q.pop_front());
      end
    end else begin
      check({tag, "_hold"}, last_rd);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    last_rd = '0;
  endtask

  initial begin
    word_t d;
    rst = 1'b1; read_en = 1'b0; write_en = 1'b0; addr = '0; write_data = '0;
    clear_model();

    // Asynchronous reset with no clock edge in between.
    #2 rst = 1'b0;
    #1 check("reset_async", '0);
    @(negedge clk) rst = 1'b1;
    for (int a = 0; a < DEPTH; a++) cycle(1'b1, 1'b0, a[ADDR_W-1:0], '0, $sformatf("reset_rd%0d", a));

    // Write then read, continuing as alternating traffic.
    d = 32'h43211234;
    for (int a = 0; a < 8; a++) begin
      cycle(1'b0, 1'b1, a[ADDR_W-1:0], d, $sformatf("alt_wr%0d", a));
      cycle(1'b1, 1'b0, a[ADDR_W-1:0], '0, $sformatf("alt_rd%0d", a));
      d = d + 32'h48791234;
    end
    cycle(1'b1, 1'b0, 4'd1, '0, "alt_addr1_recheck");
    check("alt_addr1_const", 32'h8B9A2468);
    cycle(1'b1, 1'b0, 4'd2, '0, "alt_addr2_recheck");
    check("alt_addr2_const", 32'hD413369C);

    // Same-edge read and write.
    cycle(1'b1, 1'b1, 4'd5, 32'hDEADBEEF, "same_edge");
    check("same_edge_const", 32'hDEADBEEF);
    cycle(1'b1, 1'b0, 4'd3, '0, "after_same_edge_other");
    cycle(1'b1, 1'b0, 4'd5, '0, "same_edge_reread");

    // Hold: read_en low while addr moves and other entries are written.
    cycle(1'b0, 1'b1, 4'd9,  32'h0BAD_F00D, "hold_wr9");
    cycle(1'b0, 1'b1, 4'd10, 32'h1357_9BDF, "hold_wr10");
    cycle(1'b0, 1'b0, 4'd5,  32'hFFFF_FFFF, "hold_idle");
    check("hold_const", 32'hDEADBEEF);
    cycle(1'b1, 1'b0, 4'd9,  '0, "hold_rd9");
    cycle(1'b1, 1'b0, 4'd10, '0, "hold_rd10");

    // Fill everything, then reset mid-traffic with a write pending.
    for (int a = 0; a < DEPTH; a++)
      cycle(1'b0, 1'b1, a[ADDR_W-1:0], 32'hA5000000 | word_t'(a * 32'h1111), $sformatf("fill%0d", a));
    cycle(1'b1, 1'b0, 4'd15, '0, "fill_rd15");
    @(negedge clk);
    read_en = 1'b1; write_en = 1'b1; addr = 4'd3; write_data = 32'h12345678;
    #2 rst = 1'b0;
    #1 check("reset_mid_async", '0);
    clear_model();
    @(posedge clk);
    #1 check("reset_held_edge", '0);
    @(negedge clk);
    read_en = 1'b0; write_en = 1'b0;
    rst = 1'b1;
    for (int a = 0; a < DEPTH; a++) cycle(1'b1, 1'b0, a[ADDR_W-1:0], '0, $sformatf("post_reset_rd%0d", a));

    // First edge after release operates normally.
    cycle(1'b1, 1'b1, 4'd7, 32'hCAFE_0007, "post_reset_wr7");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_reg_file_16x32

`default_nettype wire
